onehot_pulse_decoder: RTL
=========================

# onehot_pulse_decoder

Sequential inverse of the team's 4-to-2 priority encoder. It accepts a binary code with a valid flag (`q`, `v`) and regenerates the one-hot line `d` as a timed pulse. Each pulse is held for `HOLD` cycles, followed by `GAP` idle cycles. The block sits at the consumer end of an encoded request path, re-expanding a served index into a per-line strobe. A one-entry pending buffer and a ready handshake allow back-to-back codes without loss.

## Interface
Parameters:
- `CODE_W`, default 2: code width. Output width N = 2**CODE_W.
- `HOLD`, default 4: cycles each one-hot pulse is driven. Must be ≥1.
- `GAP`, default 1: all-zero cycles inserted after each pulse. Must be ≥0.

Ports:
- `clk`  in  1: single clock. All logic is on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `q`  in  CODE_W: binary code to expand. Must be stable while `v`=1 and `rdy`=0.
- `v`  in  1: code valid.
- `rdy`  out  1: block can accept a code this cycle. A transfer occurs when `v & rdy`.
- `d`  out  N: registered one-hot output. All-zero when idle or in a gap.
- `busy`  out  1: state ≠ IDLE.
- `done`  out  1: one-cycle pulse during the last cycle `d` is nonzero for a code.

## Operation
- States:
  - IDLE: `d`=0.
  - ACTIVE: `d` = 1<<code_r.
  - GAP: `d`=0.
- Down-counter `cnt`, width $clog2(max(HOLD,GAP,2)).
- Pending register: `pend_v`, `pend_q`.
- `rdy` = (state==IDLE) | !pend_v. `rdy` is combinational and has no dependence on `v`.
- IDLE:
  - On accept: code_r←q, cnt←HOLD-1, next state ACTIVE.
- ACTIVE:
  - Accept while `pend_v`=0: pend_q←q, pend_v←1.
  - When cnt==0: `done`=1 this cycle.
    - If GAP>0: go to GAP with cnt←GAP-1.
    - Else, if a next code is available: reload ACTIVE.
    - Else: go to IDLE.
  - Otherwise cnt decrements.
- GAP:
  - Accept while `pend_v`=0 loads the pending register.
  - When cnt==0: if a next code is available, ACTIVE with cnt←HOLD-1. Else IDLE.
- Next-code source at a pulse/gap boundary:
  - pend_q if `pend_v`; `pend_v` clears.
  - Otherwise `q` if `v & rdy` in that same boundary cycle; the code is consumed directly and never enters pending.
- Pending holds at most one code. With `pend_v`=1 and state ≠ IDLE, `rdy`=0.
- Every CODE_W code is legal. There is no invalid-code path.
- `done` is never asserted in IDLE or GAP.

## Timing
- Reset values, in effect from the edge where `rst`=1:
  - state=IDLE, `d`=0, `busy`=0, `done`=0, `pend_v`=0, cnt=0.
  - `rdy`=1 from the cycle after reset.
- `v` is ignored during any cycle with `rst`=1.
- Latency: accept at edge E → `d` nonzero for cycles E+1 .. E+HOLD.
- Gap occupies the following GAP cycles.
- Steady-state throughput: one code per HOLD+GAP cycles.
- GAP=0: consecutive pulses are adjacent, with no zero cycle between them.
- Reset mid-operation: the next edge forces IDLE, `d`=0, and discards the pending code. No `done` is emitted for the aborted pulse.
- Simultaneous boundary and accept: the input code wins only when `pend_v`=0, and it starts the next ACTIVE period with no IDLE cycle.

## Structure
- Package `onehot_pulse_pkg`:
  - State typedef: IDLE/ACTIVE/GAP.
  - Function `to_onehot(code)` returning N bits.
  - Localparam helper for counter width.
- Sub-module `pulse_hold_counter`: loadable down-counter.
  - Inputs: `clk`, `rst`, `load`, `load_val`.
  - Output: `zero`.
  - Used for both HOLD and GAP counts.
- Top-level contains the FSM, pending register and output register.

## Test plan
Default parameters (CODE_W=2, HOLD=4, GAP=1) unless stated.
1. Reset: hold `rst`=1 for 2 cycles with `v`=1, `q`=3 → `d`=0000, `busy`=0, `done`=0. `rdy`=1 after release; no code is accepted during reset.
2. Single code: `q`=2, `v`=1 for one cycle, accepted at edge 0 → `d`=0100 in cycles 1–4, `done` in cycle 4, `d`=0 in cycle 5, `busy`=0 from cycle 6.
3. Back-to-back: `q`=3 at cycle 0, `q`=0 held valid from cycle 1 → second code pended at cycle 1, `rdy`=0 in cycles 2–5. `d`=1000 in cycles 1–4, 0000 in cycle 5, 0001 in cycles 6–9. `rdy`=1 again from cycle 6.
4. GAP=0, HOLD=2: stream codes 1 then 2 → `d` = 0010, 0010, 0100, 0100 with no zero cycle between. `done` in cycles 2 and 4.
5. Reset mid-pulse: `rst` in the 2nd ACTIVE cycle with a pending code → `d`=0 next cycle, pending dropped, no `done`. A fresh `q`=1 afterwards gives `d`=0010 for 4 cycles.
6. Stall: present `q`=1 while `rdy`=0 and hold it until `rdy` rises → the code is accepted exactly once and produces exactly one 4-cycle pulse.

Source files
------------

// File: rtl/onehot_pulse_decoder_pkg.sv
// Shared types and helpers for the one-hot pulse decoder: FSM state encoding,
// code-to-one-hot expansion and the hold/gap counter width.
package onehot_pulse_pkg;

  localparam int unsigned MAX_CODE_W = 5;
  localparam int unsigned MAX_N      = 1 << MAX_CODE_W;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_GAP    = 2'd2
  } state_t;

  // Counter must hold both HOLD-1 and GAP-1; at least one bit wide.
  function automatic int unsigned cnt_width(input int unsigned hold, input int unsigned gap);
    int unsigned m;
    m = 2;
    if (hold > m) m = hold;
    if (gap > m) m = gap;
    return $clog2(m);
  endfunction

  function automatic logic [MAX_N-1:0] to_onehot(input logic [MAX_CODE_W-1:0] code);
    return MAX_N'(1) << code;
  endfunction

endpackage

// File: rtl/onehot_pulse_decoder_if.sv
// Code/valid request side and one-hot pulse side of the decoder.
interface onehot_pulse_decoder_if #(
  parameter int unsigned CODE_W = 2
);
  localparam int unsigned N = 1 << CODE_W;

  logic [CODE_W-1:0] q;
  logic              v;
  logic              rdy;
  logic [N-1:0]      d;
  logic              busy;
  logic              done;

  modport master (output q, v, input rdy, d, busy, done);
  modport slave  (input q, v, output rdy, d, busy, done);
endinterface

// File: rtl/onehot_pulse_decoder_counter.sv
// Loadable down-counter shared by the hold and gap phases; parks at zero.
module pulse_hold_counter #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  assign zero = (cnt == '0);
endmodule

// File: rtl/onehot_pulse_decoder.sv
// Expands a binary code into a one-hot pulse of HOLD cycles followed by GAP idle
// cycles, with a one-entry pending buffer so back-to-back codes are not lost.
module onehot_pulse_decoder
  import onehot_pulse_pkg::*;
#(
  parameter int unsigned CODE_W = 2,
  parameter int unsigned HOLD   = 4,
  parameter int unsigned GAP    = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  onehot_pulse_decoder_if.slave  bus
);
  localparam int unsigned N     = 1 << CODE_W;
  localparam int unsigned CNT_W = cnt_width(HOLD, GAP);
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = CNT_W'(GAP - 1);
  localparam logic HAS_GAP = (GAP != 0);

  state_t            state, state_nxt;
  logic [CODE_W-1:0] code_r, code_nxt;
  logic [CODE_W-1:0] pend_q, pend_q_nxt;
  logic              pend_v, pend_v_nxt;
  logic              cnt_load;
  logic [CNT_W-1:0]  cnt_load_val;
  logic              cnt_zero;
  logic              accept;
  logic              to_gap;
  logic [N-1:0]      d_r, d_nxt;

  pulse_hold_counter #(.W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .zero     (cnt_zero)
  );

  assign bus.rdy = (state == ST_IDLE) | ~pend_v;
  assign accept  = bus.v & bus.rdy;
  assign to_gap  = (state == ST_ACTIVE) & HAS_GAP;

  // State, code and pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= ST_IDLE;
      code_r <= '0;
      pend_q <= '0;
      pend_v <= 1'b0;
    end else begin
      state  <= state_nxt;
      code_r <= code_nxt;
      pend_q <= pend_q_nxt;
      pend_v <= pend_v_nxt;
    end
  end

  // Next state; at a boundary the pending code beats a same-cycle input code
  always_comb begin
    state_nxt    = state;
    code_nxt     = code_r;
    pend_q_nxt   = pend_q;
    pend_v_nxt   = pend_v;
    cnt_load     = 1'b0;
    cnt_load_val = HOLD_LD;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          state_nxt = ST_ACTIVE;
          code_nxt  = bus.q;
          cnt_load  = 1'b1;
        end
      end
      ST_ACTIVE, ST_GAP: begin
        if (!cnt_zero || to_gap) begin
          if (accept) begin
            pend_q_nxt = bus.q;
            pend_v_nxt = 1'b1;
          end
          if (cnt_zero) begin
            state_nxt    = ST_GAP;
            cnt_load     = 1'b1;
            cnt_load_val = GAP_LD;
          end
        end else if (pend_v) begin
          state_nxt  = ST_ACTIVE;
          code_nxt   = pend_q;
          pend_v_nxt = 1'b0;
          cnt_load   = 1'b1;
        end else if (accept) begin
          state_nxt = ST_ACTIVE;
          code_nxt  = bus.q;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs; d is precomputed from the next state so it lines up with ACTIVE
  always_comb begin
    bus.busy = (state != ST_IDLE);
    bus.done = (state == ST_ACTIVE) & cnt_zero;
    d_nxt    = '0;
    if (state_nxt == ST_ACTIVE) begin
      d_nxt = N'(to_onehot(MAX_CODE_W'(code_nxt)));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_r <= '0;
    end else begin
      d_r <= d_nxt;
    end
  end

  assign bus.d = d_r;
endmodule
